// File: rtl/agat_pkg.sv
// Shared definitions for the Agat sector fetch path: FSM states, fetch status codes
// and the 4&4 address-field decode used by both the reader and the address-field writer.
package agat_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HUNT,
    S_ADDR,
    S_WAIT_DATA,
    S_DATA,
    S_FINISH
  } state_t;

  typedef enum logic [1:0] {
    ST_OK          = 2'd0,
    ST_NOT_FOUND   = 2'd1,
    ST_SHORT_FIELD = 2'd2,
    ST_ABORTED     = 2'd3
  } status_t;

  // 4&4: odd byte carries value bits 7,5,3,1 and even byte carries 6,4,2,0, both ORed with 0xAA.
  function automatic logic [7:0] dec44(input logic [7:0] odd, input logic [7:0] even);
    return {odd[6:0], 1'b1} & even;
  endfunction

endpackage

// File: rtl/agat_addr_field_decoder.sv
// Captures the 8 raw address-field bytes, 4&4-decodes them and reports checksum and
// target match combinationally while the eighth byte is on byte_in.
module agat_addr_field_decoder
  import agat_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       restart,
  input  logic       capture,
  input  logic [7:0] byte_in,
  input  logic [1:0] format_in,
  input  logic [7:0] target_track,
  input  logic [7:0] target_sector,
  output logic       at_last,
  output logic       chk_ok,
  output logic       match,
  output logic [7:0] volume,
  output logic [1:0] format
);

  logic [2:0] byte_idx;
  logic [7:0] raw [0:6];
  logic [1:0] fmt_q;
  logic [7:0] vol, trk, sec, chk;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_idx <= '0;
      fmt_q    <= '0;
      for (int i = 0; i < 7; i++) raw[i] <= '0;
    end else if (restart) begin
      byte_idx <= '0;
      fmt_q    <= format_in;
    end else if (capture) begin
      if (byte_idx != 3'd7) raw[byte_idx] <= byte_in;
      byte_idx <= byte_idx + 3'd1;
    end
  end

  // The checksum pair's even byte is never stored; it is decoded straight off the bus.
  always_comb begin
    vol = dec44(raw[0], raw[1]);
    trk = dec44(raw[2], raw[3]);
    sec = dec44(raw[4], raw[5]);
    chk = dec44(raw[6], byte_in);
  end

  assign at_last = (byte_idx == 3'd7);
  assign chk_ok  = ((vol ^ trk ^ sec ^ chk) == 8'h00);
  assign match   = (trk == target_track) && (sec == target_sector);
  assign volume  = vol;
  assign format  = fmt_q;

endmodule

// File: rtl/agat_sector_sequencer.sv
// Command-driven single-sector fetch: hunts an address field, matches track/sector,
// then forwards the following raw data field, with optional Apple-then-native probing.
module agat_sector_sequencer
  import agat_pkg::*;
#(
  parameter int DATA_BYTES  = 343,
  parameter int DATA_WINDOW = 32,
  parameter int MAX_REVS    = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_start,
  input  logic       cmd_abort,
  input  logic       auto_probe,
  input  logic       native_first,
  input  logic [7:0] target_track,
  input  logic [7:0] target_sector,
  input  logic       index_pulse,
  input  logic       det_addr_mark,
  input  logic       det_data_mark,
  input  logic [7:0] det_byte,
  input  logic       det_byte_ready,
  input  logic [1:0] det_format,
  output logic       det_enable,
  output logic       det_agat_native,
  output logic [7:0] out_byte,
  output logic       out_valid,
  output logic       busy,
  output logic       done,
  output logic [1:0] status,
  output logic [7:0] found_volume,
  output logic [1:0] found_format,
  output logic [7:0] hdr_err_cnt
);

  state_t     state_q, state_d;
  logic [7:0] tgt_track_q, tgt_sector_q;
  logic [1:0] rev_cnt_q;
  logic [5:0] gap_cnt_q;
  logic [8:0] data_cnt_q;
  logic [1:0] status_q, status_d;
  logic       first_try_q, mode_gap_q, native_q;
  logic [7:0] hdr_err_q, found_vol_q;
  logic [1:0] found_fmt_q;
  logic [7:0] byte_p1;
  logic       vld_p1;

  logic dec_restart, dec_capture, dec_at_last, dec_chk_ok, dec_match;
  logic [7:0] dec_volume;
  logic [1:0] dec_format;

  logic rev_phase, timeout, rev_inc, do_probe, start_fetch, emit, status_set;
  logic err_inc, found_latch, gap_clr, gap_inc, data_clr;

  agat_addr_field_decoder u_addr (
    .clk           (clk),
    .reset_n       (reset_n),
    .restart       (dec_restart),
    .capture       (dec_capture),
    .byte_in       (det_byte),
    .format_in     (det_format),
    .target_track  (tgt_track_q),
    .target_sector (tgt_sector_q),
    .at_last       (dec_at_last),
    .chk_ok        (dec_chk_ok),
    .match         (dec_match),
    .volume        (dec_volume),
    .format        (dec_format)
  );

  assign rev_phase = (state_q == S_HUNT) || (state_q == S_ADDR) || (state_q == S_WAIT_DATA);
  assign timeout   = rev_phase && index_pulse && (rev_cnt_q == 2'(MAX_REVS - 1));
  assign rev_inc   = rev_phase && index_pulse && !timeout;

  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    status_set  = 1'b0;
    start_fetch = 1'b0;
    do_probe    = 1'b0;
    dec_restart = 1'b0;
    dec_capture = 1'b0;
    emit        = 1'b0;
    err_inc     = 1'b0;
    found_latch = 1'b0;
    gap_clr     = 1'b0;
    gap_inc     = 1'b0;
    data_clr    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_start) begin
          start_fetch = 1'b1;
          state_d     = S_HUNT;
        end
      end
      // The fetch has already ended here; a late abort must not produce a second done.
      S_FINISH: state_d = S_IDLE;
      default: begin
        if (cmd_abort) begin
          status_set = 1'b1;
          status_d   = ST_ABORTED;
          state_d    = S_FINISH;
        end else if (timeout) begin
          if (auto_probe && first_try_q) begin
            do_probe = 1'b1;
            state_d  = S_HUNT;
          end else begin
            status_set = 1'b1;
            status_d   = ST_NOT_FOUND;
            state_d    = S_FINISH;
          end
        end else if (!mode_gap_q) begin
          case (state_q)
            S_HUNT: begin
              if (det_addr_mark) begin
                dec_restart = 1'b1;
                state_d     = S_ADDR;
              end
            end
            S_ADDR: begin
              if (det_addr_mark) begin
                dec_restart = 1'b1;
              end else if (det_byte_ready) begin
                dec_capture = 1'b1;
                if (dec_at_last) begin
                  if (!dec_chk_ok) begin
                    err_inc = 1'b1;
                    state_d = S_HUNT;
                  end else if (!dec_match) begin
                    state_d = S_HUNT;
                  end else begin
                    found_latch = 1'b1;
                    gap_clr     = 1'b1;
                    state_d     = S_WAIT_DATA;
                  end
                end
              end
            end
            S_WAIT_DATA: begin
              if (det_addr_mark) begin
                state_d = S_HUNT;
              end else if (det_data_mark) begin
                data_clr = 1'b1;
                state_d  = S_DATA;
              end else if (gap_cnt_q == 6'(DATA_WINDOW)) begin
                state_d = S_HUNT;
              end else if (det_byte_ready) begin
                gap_inc = 1'b1;
              end
            end
            S_DATA: begin
              if (det_addr_mark || det_data_mark) begin
                status_set = 1'b1;
                status_d   = ST_SHORT_FIELD;
                state_d    = S_FINISH;
              end else if (det_byte_ready) begin
                emit = 1'b1;
                if (data_cnt_q == 9'(DATA_BYTES - 1)) begin
                  status_set = 1'b1;
                  status_d   = ST_OK;
                  state_d    = S_FINISH;
                end
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      tgt_track_q  <= '0;
      tgt_sector_q <= '0;
      rev_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      data_cnt_q   <= '0;
      status_q     <= ST_OK;
      first_try_q  <= 1'b0;
      mode_gap_q   <= 1'b0;
      native_q     <= 1'b0;
      hdr_err_q    <= '0;
      found_vol_q  <= '0;
      found_fmt_q  <= '0;
      byte_p1      <= '0;
      vld_p1       <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_gap_q <= do_probe;
      // Output stage: one cycle behind the detector strobe
      vld_p1     <= emit;
      if (emit) byte_p1 <= det_byte;
      if (start_fetch) begin
        tgt_track_q  <= target_track;
        tgt_sector_q <= target_sector;
        native_q     <= native_first;
        rev_cnt_q    <= '0;
        hdr_err_q    <= '0;
        status_q     <= ST_OK;
        first_try_q  <= 1'b1;
      end
      if (rev_inc) rev_cnt_q <= rev_cnt_q + 2'd1;
      if (do_probe) begin
        rev_cnt_q   <= '0;
        native_q    <= ~native_q;
        first_try_q <= 1'b0;
      end
      if (status_set) status_q <= status_d;
      if (err_inc && hdr_err_q != 8'hFF) hdr_err_q <= hdr_err_q + 8'd1;
      if (found_latch) begin
        found_vol_q <= dec_volume;
        found_fmt_q <= dec_format;
      end
      if (gap_clr) gap_cnt_q <= '0;
      else if (gap_inc) gap_cnt_q <= gap_cnt_q + 6'd1;
      if (data_clr) data_cnt_q <= '0;
      else if (emit) data_cnt_q <= data_cnt_q + 9'd1;
    end
  end

  assign busy            = (state_q != S_IDLE) && (state_q != S_FINISH);
  assign det_enable      = busy && !mode_gap_q;
  assign det_agat_native = native_q;
  assign done            = (state_q == S_FINISH);
  assign status          = status_q;
  assign out_byte        = byte_p1;
  assign out_valid       = vld_p1;
  assign found_volume    = found_vol_q;
  assign found_format    = found_fmt_q;
  assign hdr_err_cnt     = hdr_err_q;

endmodule

// File: tb/tb_agat_sector_sequencer.sv
// Bench for agat_sector_sequencer: table of whole-sector fetches plus hand-written
// timeout, probe, abort and reset sequences, with a queue scoreboard on out_byte.
module tb_agat_sector_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_start = 1'b0, cmd_abort = 1'b0, auto_probe = 1'b0, native_first = 1'b0;
  logic [7:0] target_track = '0, target_sector = '0;
  logic       index_pulse = 1'b0, det_addr_mark = 1'b0, det_data_mark = 1'b0;
  logic [7:0] det_byte = '0;
  logic       det_byte_ready = 1'b0;
  logic [1:0] det_format = '0;
  logic       det_enable, det_agat_native, out_valid, busy, done;
  logic [7:0] out_byte, found_volume, hdr_err_cnt;
  logic [1:0] status, found_format;

  int errors = 0;
  int checks = 0;
  int n_valid = 0;
  int done_cnt = 0;
  logic [7:0] exp_q[$];

  agat_sector_sequencer dut (
    .clk(clk), .reset_n(reset_n), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
    .auto_probe(auto_probe), .native_first(native_first), .target_track(target_track),
    .target_sector(target_sector), .index_pulse(index_pulse), .det_addr_mark(det_addr_mark),
    .det_data_mark(det_data_mark), .det_byte(det_byte), .det_byte_ready(det_byte_ready),
    .det_format(det_format), .det_enable(det_enable), .det_agat_native(det_agat_native),
    .out_byte(out_byte), .out_valid(out_valid), .busy(busy), .done(done), .status(status),
    .found_volume(found_volume), .found_format(found_format), .hdr_err_cnt(hdr_err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_valid_unexpected: got byte %0h with nothing expected", out_byte);
      end else begin
        chk("out_byte", {24'b0, out_byte}, {24'b0, exp_q.pop_front()});
      end
    end
    if (reset_n && done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] enc44(input logic [7:0] v);
    return {(v >> 1) | 8'hAA, v | 8'hAA};
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit fwd);
    det_byte = b;
    det_byte_ready = 1'b1;
    if (fwd) exp_q.push_back(b);
    tick();
    det_byte_ready = 1'b0;
  endtask

  // Marks arrive together with the prologue byte strobe, which must not count as data.
  task automatic mark(input bit is_addr);
    det_addr_mark = is_addr;
    det_data_mark = !is_addr;
    det_byte = is_addr ? 8'h96 : 8'hAD;
    det_byte_ready = 1'b1;
    tick();
    det_addr_mark = 1'b0;
    det_data_mark = 1'b0;
    det_byte_ready = 1'b0;
  endtask

  task automatic send_header(input logic [7:0] vol, input logic [7:0] trk,
                             input logic [7:0] sec, input bit bad);
    logic [7:0] f [0:3];
    logic [15:0] e;
    f[0] = vol; f[1] = trk; f[2] = sec;
    f[3] = vol ^ trk ^ sec ^ (bad ? 8'h01 : 8'h00);
    mark(1'b1);
    for (int k = 0; k < 4; k++) begin
      e = enc44(f[k]);
      send_byte(e[15:8], 1'b0);
      send_byte(e[7:0], 1'b0);
    end
  endtask

  task automatic start(input logic [7:0] trk, input logic [7:0] sec,
                       input logic ap, input logic nat);
    target_track = trk;
    target_sector = sec;
    auto_probe = ap;
    native_first = nat;
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
  endtask

  task automatic pulse_index();
    index_pulse = 1'b1;
    tick();
    index_pulse = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    for (int k = 0; k < limit && !done; k++) tick();
    chk("done_seen", {31'b0, done}, 32'd1);
  endtask

  typedef struct {
    logic [7:0] vol, trk, sec;
    int         pre;     // 0 none, 1 decoy sector header, 2 bad-checksum header
    int         gap;     // bytes between address field and data mark
    int         n_data;  // data bytes before the field ends or is cut
    logic [1:0] exp_status;
    logic [7:0] exp_err;
  } vec_t;

  vec_t vecs [0:3];

  initial begin
    vecs[0] = '{8'hFE, 8'h11, 8'h05, 0, 31, 343, 2'd0, 8'd0};
    vecs[1] = '{8'hFE, 8'h11, 8'h05, 1, 3, 343, 2'd0, 8'd0};
    vecs[2] = '{8'h01, 8'h22, 8'h0A, 2, 5, 343, 2'd0, 8'd1};
    vecs[3] = '{8'h7F, 8'h11, 8'h05, 0, 2, 100, 2'd2, 8'd0};

    repeat (3) tick();
    chk("reset_busy", {31'b0, busy}, 0);
    chk("reset_done", {31'b0, done}, 0);
    chk("reset_enable", {31'b0, det_enable}, 0);
    chk("reset_native", {31'b0, det_agat_native}, 0);
    chk("reset_status", {30'b0, status}, 0);
    chk("reset_out_valid", {31'b0, out_valid}, 0);
    reset_n = 1'b1;
    tick();
    chk("idle_enable", {31'b0, det_enable}, 0);

    for (int i = 0; i < 4; i++) begin
      int nv0;
      nv0 = n_valid;
      start(vecs[i].trk, vecs[i].sec, 1'b0, 1'b0);
      chk("start_busy", {31'b0, busy}, 1);
      chk("start_enable", {31'b0, det_enable}, 1);
      if (vecs[i].pre != 0) begin
        det_format = 2'(i + 1);
        if (vecs[i].pre == 1) send_header(vecs[i].vol, vecs[i].trk, vecs[i].sec - 8'd1, 1'b0);
        else send_header(vecs[i].vol, vecs[i].trk, vecs[i].sec, 1'b1);
        mark(1'b0);
        for (int k = 0; k < 10; k++) send_byte(8'(k + 8'h40), 1'b0);
      end
      det_format = 2'(i);
      send_header(vecs[i].vol, vecs[i].trk, vecs[i].sec, 1'b0);
      for (int k = 0; k < vecs[i].gap; k++) send_byte(8'hFF, 1'b0);
      mark(1'b0);
      for (int k = 0; k < vecs[i].n_data; k++) send_byte(8'(k * 13 + i * 5 + 1), 1'b1);
      if (vecs[i].n_data < 343) mark(1'b1);
      wait_done(4);
      chk("status", {30'b0, status}, {30'b0, vecs[i].exp_status});
      chk("found_volume", {24'b0, found_volume}, {24'b0, vecs[i].vol});
      chk("found_format", {30'b0, found_format}, i);
      chk("hdr_err_cnt", {24'b0, hdr_err_cnt}, {24'b0, vecs[i].exp_err});
      chk("done_busy", {31'b0, busy}, 0);
      tick();
      chk("done_one_cycle", {31'b0, done}, 0);
      chk("valid_count", n_valid - nv0, vecs[i].n_data);
      chk("queue_drained", exp_q.size(), 0);
      tick();
    end

    // Probe: two revolutions in Apple mode, one-cycle enable gap, two more in native mode
    start(8'h30, 8'h0F, 1'b1, 1'b0);
    pulse_index();
    repeat (3) tick();
    chk("probe_native_before", {31'b0, det_agat_native}, 0);
    pulse_index();
    chk("probe_native_after", {31'b0, det_agat_native}, 1);
    chk("probe_enable_gap", {31'b0, det_enable}, 0);
    chk("probe_busy_gap", {31'b0, busy}, 1);
    tick();
    chk("probe_enable_back", {31'b0, det_enable}, 1);
    pulse_index();
    repeat (2) tick();
    chk("probe_not_done", {31'b0, done}, 0);
    pulse_index();
    chk("probe_timeout_done", {31'b0, done}, 1);
    chk("probe_status", {30'b0, status}, 1);
    chk("probe_native_kept", {31'b0, det_agat_native}, 1);
    repeat (2) tick();

    // No probe; a cmd_start while busy must not reset the revolution count
    start(8'h30, 8'h0F, 1'b0, 1'b1);
    chk("noprobe_native", {31'b0, det_agat_native}, 1);
    pulse_index();
    start(8'h11, 8'h05, 1'b0, 1'b0);
    pulse_index();
    chk("noprobe_done", {31'b0, done}, 1);
    chk("noprobe_status", {30'b0, status}, 1);
    chk("noprobe_native_kept", {31'b0, det_agat_native}, 1);
    repeat (2) tick();

    // Data window expiry, then abort coinciding with a byte strobe in DATA
    begin
      int nv0;
      nv0 = n_valid;
      start(8'h11, 8'h05, 1'b0, 1'b0);
      send_header(8'h22, 8'h11, 8'h05, 1'b0);
      for (int k = 0; k < 32; k++) send_byte(8'hFF, 1'b0);
      tick();
      mark(1'b0);
      for (int k = 0; k < 5; k++) send_byte(8'h55, 1'b0);
      chk("window_no_output", n_valid - nv0, 0);
      send_header(8'h22, 8'h11, 8'h05, 1'b0);
      mark(1'b0);
      for (int k = 0; k < 5; k++) send_byte(8'(8'hC0 + k), 1'b1);
      det_byte = 8'hEE;
      det_byte_ready = 1'b1;
      cmd_abort = 1'b1;
      tick();
      det_byte_ready = 1'b0;
      cmd_abort = 1'b0;
      chk("abort_done", {31'b0, done}, 1);
      chk("abort_status", {30'b0, status}, 3);
      chk("abort_busy", {31'b0, busy}, 0);
      repeat (2) tick();
      chk("abort_valid_count", n_valid - nv0, 5);
      chk("abort_queue_drained", exp_q.size(), 0);
    end

    // Asynchronous reset in the middle of a data field
    begin
      int dc0;
      start(8'h11, 8'h05, 1'b0, 1'b1);
      send_header(8'h33, 8'h11, 8'h05, 1'b0);
      mark(1'b0);
      for (int k = 0; k < 10; k++) send_byte(8'(k), 1'b1);
      dc0 = done_cnt;
      #2;
      reset_n = 1'b0;
      #1;
      exp_q.delete();
      chk("areset_busy", {31'b0, busy}, 0);
      chk("areset_out_valid", {31'b0, out_valid}, 0);
      chk("areset_native", {31'b0, det_agat_native}, 0);
      chk("areset_found_volume", {24'b0, found_volume}, 0);
      repeat (2) tick();
      #3;
      reset_n = 1'b1;
      repeat (3) tick();
      chk("areset_no_done", done_cnt - dc0, 0);
      chk("areset_idle_enable", {31'b0, det_enable}, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
